// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the serial program loader: sync byte, FSM encodings
// for the loader and the UART receiver, and the baud divider helper.
package uart_prog_loader_pkg;

    // First byte of every load frame.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Loader frame FSM. LD_CHECK is only entered when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_COUNT = 3'd1,
        LD_DATA  = 3'd2,
        LD_CHECK = 3'd3,
        LD_FIN   = 3'd4
    } ld_state_t;

    // UART receiver bit FSM.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Number of clk cycles per UART bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detection with a
// mid-start-bit glitch re-check, LSB-first data sampling at bit centres, and a
// stop-bit check that yields either rx_valid or rx_frame_err for one cycle.
module uart_rx_core
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rxd_meta_reg;
    logic             rxd_sync_reg;
    logic             rxd_prev_reg;
    rx_state_t        state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg,   shift_next;
    logic [7:0]       data_reg,    data_next;
    logic             valid_reg,   valid_next;
    logic             ferr_reg,    ferr_next;

    // Bring rxd into the clk domain; idle level is high so reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_reg <= 1'b1;
            rxd_sync_reg <= 1'b1;
            rxd_prev_reg <= 1'b1;
        end else begin
            rxd_meta_reg <= rxd;
            rxd_sync_reg <= rxd_meta_reg;
            rxd_prev_reg <= rxd_sync_reg;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
        end
    end

    // Bit timing and sampling; strobes are single-cycle by default-low.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                // Only a true 1->0 transition starts a byte, so a line held
                // low after a framing error does not retrigger.
                if (rxd_prev_reg && !rxd_sync_reg) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rxd_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rxd_sync_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    if (rxd_sync_reg) begin
                        valid_next = 1'b1;
                        data_next  = shift_reg;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_data      = data_reg;
    assign rx_valid     = valid_reg;
    assign rx_frame_err = ferr_reg;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader. Receives frames of the form
//   A5, N, N*4 data bytes (little-endian words) [, checksum]
// over UART and writes the words to instruction memory from address 0,
// holding the core while a load is in flight.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum byte
// (sum mod 256 of the count byte and all data bytes) checked before FIN.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 25000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int CNT_W        = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 1 << ADDR_W;
    localparam int TMR_W        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    ld_state_t         state_reg,    state_next;
    logic [CNT_W-1:0]  count_reg,    count_next;
    logic [CNT_W-1:0]  index_reg,    index_next;
    logic [1:0]        byte_cnt_reg, byte_cnt_next;
    logic [31:0]       word_reg,     word_next;
    logic              we_reg,       we_next;
    logic [ADDR_W-1:0] addr_reg,     addr_next;
    logic [31:0]       wdata_reg,    wdata_next;
    logic              hold_reg,     hold_next;
    logic              done_reg,     done_next;
    logic              err_reg,      err_next;
    logic [TMR_W-1:0]  timer_reg,    timer_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_reg,     csum_next;
`endif

    logic [CNT_W-1:0]  n_clamped;
    logic              in_frame;
    logic              timeout;

    // Word count from the count byte: 0 and anything above the memory depth
    // both mean "fill the whole memory".
    always_comb begin
        if (rx_data == 8'd0 || 32'(rx_data) > MAX_WORDS) begin
            n_clamped = CNT_W'(MAX_WORDS);
        end else begin
            n_clamped = CNT_W'(rx_data);
        end
    end

    assign in_frame = (state_reg == LD_COUNT) || (state_reg == LD_DATA) ||
                      (state_reg == LD_CHECK);
    assign timeout  = in_frame && !rx_valid && (timer_reg == TMR_LAST);

    // Loader state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= LD_IDLE;
            count_reg    <= '0;
            index_reg    <= '0;
            byte_cnt_reg <= '0;
            word_reg     <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            hold_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            timer_reg    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            index_reg    <= index_next;
            byte_cnt_reg <= byte_cnt_next;
            word_reg     <= word_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            hold_reg     <= hold_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            timer_reg    <= timer_next;
`ifdef LOADER_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    // Frame parsing, word assembly, write strobe and abort handling.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        index_next    = index_reg;
        byte_cnt_next = byte_cnt_reg;
        word_next     = word_reg;
        we_next       = 1'b0;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        hold_next     = hold_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        timer_next    = '0;
`ifdef LOADER_CHECKSUM_EN
        csum_next     = csum_reg;
`endif
        // Inter-byte timer only runs while a frame is open.
        if (in_frame && !rx_valid) begin
            timer_next = timer_reg + TMR_W'(1);
        end

        case (state_reg)
            LD_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    hold_next  = 1'b1;
                    err_next   = 1'b0;
                    state_next = LD_COUNT;
                end
            end
            LD_COUNT: begin
                if (rx_valid) begin
                    count_next    = n_clamped;
                    index_next    = '0;
                    byte_cnt_next = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_next     = rx_data;
`endif
                    state_next    = LD_DATA;
                end
            end
            LD_DATA: begin
                if (rx_valid) begin
                    // Little-endian: first byte ends up in bits [7:0].
                    word_next     = {rx_data, word_reg[31:8]};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_next     = csum_reg + rx_data;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        we_next    = 1'b1;
                        addr_next  = index_reg[ADDR_W-1:0];
                        wdata_next = word_next;
                        index_next = index_reg + CNT_W'(1);
                        if (index_reg + CNT_W'(1) == count_reg) begin
`ifdef LOADER_CHECKSUM_EN
                            state_next = LD_CHECK;
`else
                            state_next = LD_FIN;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum_reg) begin
                        state_next = LD_FIN;
                    end else begin
                        err_next   = 1'b1;
                        state_next = LD_IDLE;
                    end
                end
            end
`endif
            LD_FIN: begin
                done_next  = 1'b1;
                hold_next  = 1'b0;
                state_next = LD_IDLE;
            end
            default: state_next = LD_IDLE;
        endcase

        // Framing error or inter-byte timeout abandons the frame; the core
        // stays held because memory is only partially written.
        if (in_frame && (rx_frame_err || timeout)) begin
            state_next = LD_IDLE;
            err_next   = 1'b1;
            we_next    = 1'b0;
        end
    end

    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign cpu_hold  = hold_reg;
    assign load_done = done_reg;
    assign load_err  = err_reg;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a behavioural 8N1 UART driver.
// A fast bit rate and short timeout keep the run short; ADDR_W=2 makes the
// count-zero (full memory) case four words long.
// With LOADER_CHECKSUM_EN defined, payloads get a checksum byte appended and
// the checksum pass/fail case is exercised as well.
module tb_uart_prog_loader;

    localparam int CLK_HZ = 25_000_000;
    localparam int BAUD_R = 1_562_500;
    localparam int AW     = 2;
    localparam int TMO    = 1000;
    localparam int CPB    = CLK_HZ / BAUD_R;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [7:0]    tx_q[$];

    uart_prog_loader #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .ADDR_W      (AW),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #20 clk = ~clk;

    // Log every memory write and completion pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            $display("write addr=%0d data=%08h", mem_addr, mem_wdata);
        end
        if (load_done) begin
            done_cnt++;
            $display("load_done pulse");
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        $display("tx byte %02h stop=%0d", b, stop_bit);
    endtask

    // Sends tx_q (count byte + data bytes), plus checksum when enabled.
    task automatic send_payload();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'h00;
`endif
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], 1'b1);
`ifdef LOADER_CHECKSUM_EN
            sum = sum + tx_q[i];
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum, 1'b1);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_vec++; if (mem_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        n_vec++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %08h want 0", mem_wdata); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b want 0", cpu_hold); end
        n_vec++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", load_done); end
        n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", load_err); end
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_basic_load();
        clear_log();
        send_byte(8'hA5, 1'b1);
        n_vec++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL basic_hold_on: got %b want 1", cpu_hold); end
        tx_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_payload();
        n_vec++; if (wr_addr_q.size() != 2) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 2) begin
            n_vec++; if (wr_addr_q[0] !== 2'd0) begin n_bad++; $display("FAIL basic_addr0: got %0d want 0", wr_addr_q[0]); end
            n_vec++; if (wr_data_q[0] !== 32'h00000013) begin n_bad++; $display("FAIL basic_data0: got %08h want 00000013", wr_data_q[0]); end
            n_vec++; if (wr_addr_q[1] !== 2'd1) begin n_bad++; $display("FAIL basic_addr1: got %0d want 1", wr_addr_q[1]); end
            n_vec++; if (wr_data_q[1] !== 32'h00100093) begin n_bad++; $display("FAIL basic_data1: got %08h want 00100093", wr_data_q[1]); end
        end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL basic_hold_off: got %b want 0", cpu_hold); end
        n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", load_err); end
    endtask

    task automatic test_ignore_noise();
        logic [7:0] noise [3];
        noise = '{8'h00, 8'hFF, 8'h5A};
        clear_log();
        for (int i = 0; i < 3; i++) begin
            send_byte(noise[i], 1'b1);
            n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL noise_hold%0d: got %b want 0", i, cpu_hold); end
        end
        n_vec++; if (wr_addr_q.size() != 0) begin n_bad++; $display("FAIL noise_nwrites: got %0d want 0", wr_addr_q.size()); end
        send_byte(8'hA5, 1'b1);
        n_vec++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL noise_hold_sync: got %b want 1", cpu_hold); end
        tx_q = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_payload();
        n_vec++; if (wr_data_q.size() != 1) begin n_bad++; $display("FAIL noise_nwrites2: got %0d want 1", wr_data_q.size()); end
        if (wr_data_q.size() >= 1) begin
            n_vec++; if (wr_data_q[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL noise_data: got %08h want DEADBEEF", wr_data_q[0]); end
        end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL noise_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL noise_hold_off: got %b want 0", cpu_hold); end
    endtask

    task automatic test_count_zero();
        logic [31:0] exp_d [4];
        exp_d = '{32'h40302010, 32'h41312111, 32'h42322212, 32'h43332313};
        clear_log();
        send_byte(8'hA5, 1'b1);
        tx_q.delete();
        tx_q.push_back(8'h00);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                tx_q.push_back(8'(16 * (j + 1) + k));
            end
        end
        send_payload();
        repeat (4 * CPB) @(negedge clk);
        n_vec++; if (wr_addr_q.size() != 4) begin n_bad++; $display("FAIL cz_nwrites: got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_vec++; if (wr_addr_q[i] !== AW'(i)) begin n_bad++; $display("FAIL cz_addr%0d: got %0d want %0d", i, wr_addr_q[i], i); end
            n_vec++; if (wr_data_q[i] !== exp_d[i]) begin n_bad++; $display("FAIL cz_data%0d: got %08h want %08h", i, wr_data_q[i], exp_d[i]); end
        end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL cz_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL cz_hold: got %b want 0", cpu_hold); end
    endtask

    task automatic test_framing_err();
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        send_byte(8'h99, 1'b1);
        n_vec++; if (wr_data_q.size() != 1) begin n_bad++; $display("FAIL fe_nwrites: got %0d want 1", wr_data_q.size()); end
        if (wr_data_q.size() >= 1) begin
            n_vec++; if (wr_data_q[0] !== 32'h44332211) begin n_bad++; $display("FAIL fe_data: got %08h want 44332211", wr_data_q[0]); end
        end
        n_vec++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL fe_err: got %b want 1", load_err); end
        n_vec++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL fe_hold: got %b want 1", cpu_hold); end
        n_vec++; if (done_cnt != 0) begin n_bad++; $display("FAIL fe_done: got %0d pulses want 0", done_cnt); end
        // Recovery frame; A5 inside the data is payload.
        send_byte(8'hA5, 1'b1);
        n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL fe_err_clear: got %b want 0", load_err); end
        tx_q = '{8'h01, 8'hA5, 8'hA5, 8'h00, 8'h5A};
        send_payload();
        n_vec++; if (wr_data_q.size() != 2) begin n_bad++; $display("FAIL fe_nwrites2: got %0d want 2", wr_data_q.size()); end
        if (wr_data_q.size() >= 2) begin
            n_vec++; if (wr_addr_q[1] !== 2'd0) begin n_bad++; $display("FAIL fe_addr2: got %0d want 0", wr_addr_q[1]); end
            n_vec++; if (wr_data_q[1] !== 32'h5A00A5A5) begin n_bad++; $display("FAIL fe_data2: got %08h want 5A00A5A5", wr_data_q[1]); end
        end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL fe_done2: got %0d pulses want 1", done_cnt); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL fe_hold2: got %b want 0", cpu_hold); end
    endtask

    task automatic test_timeout();
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h21, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h65, 1'b1);
        repeat (800) @(negedge clk);
        n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", load_err); end
        repeat (300) @(negedge clk);
        n_vec++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", load_err); end
        n_vec++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL to_hold: got %b want 1", cpu_hold); end
        // A fourth byte must not complete the abandoned word.
        send_byte(8'h87, 1'b1);
        n_vec++; if (wr_data_q.size() != 0) begin n_bad++; $display("FAIL to_nwrites: got %0d want 0", wr_data_q.size()); end
        n_vec++; if (done_cnt != 0) begin n_bad++; $display("FAIL to_done: got %0d pulses want 0", done_cnt); end
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rxd = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL rm_hold: got %b want 0", cpu_hold); end
        n_vec++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rm_we: got %b want 0", mem_we); end
        n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL rm_err: got %b want 0", load_err); end
        n_vec++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rm_wdata: got %08h want 0", mem_wdata); end
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        n_vec++; if (wr_data_q.size() != 0) begin n_bad++; $display("FAIL rm_nwrites: got %0d want 0", wr_data_q.size()); end
        send_byte(8'hA5, 1'b1);
        tx_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_payload();
        n_vec++; if (wr_data_q.size() != 2) begin n_bad++; $display("FAIL rm_nwrites2: got %0d want 2", wr_data_q.size()); end
        if (wr_data_q.size() >= 2) begin
            n_vec++; if (wr_data_q[1] !== 32'h00100093) begin n_bad++; $display("FAIL rm_data1: got %08h want 00100093", wr_data_q[1]); end
        end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL rm_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL rm_hold2: got %b want 0", cpu_hold); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        // 01+10+20+30+9F = 0x100 -> checksum 00.
        clear_log();
        send_byte(8'hA5, 1'b1);
        tx_q = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h9F, 8'h00};
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL cs_good_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL cs_good_err: got %b want 0", load_err); end
        send_byte(8'hA5, 1'b1);
        tx_q = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h9F, 8'hFF};
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL cs_bad_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL cs_bad_err: got %b want 1", load_err); end
        n_vec++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL cs_bad_hold: got %b want 1", cpu_hold); end
        n_vec++; if (wr_data_q.size() != 2) begin n_bad++; $display("FAIL cs_nwrites: got %0d want 2", wr_data_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_ignore_noise();
        test_count_zero();
        test_framing_err();
        test_timeout();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
